catch_judge: RTL
================

// Module: catch_judge
// PURPOSE
//  Consumer end of the falling-block interface driven by the block generator. Reads the six
//  10-bit slot positions (pos_blocks) and 2-bit lanes (blocks) and compares them with the
//  player lane. Resolves every fall exactly once, as a catch or a miss, and keeps score and
//  lives. Sits between the block generator and the display/scene controller; game_over feeds
//  scene sequencing.
// PARAMETERS
//  CATCH_LO   380  lowest on-screen position (inclusive) at which a block can be caught
//  CATCH_HI   409  highest position (inclusive) of the catch window
//  LAND_POS   410  landing position; an unresolved block here is a miss
//  LIVES      3    lives loaded at game start (1..3)
//  SCORE_MAX  999  score saturation value
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-high
//  scene        in   2   scene code; scene[0]=1 means playing
//  pos_blocks   in   60  slot i position = pos_blocks[10i+9:10i], i=0..5
//  blocks       in   12  slot i lane = blocks[2i+1:2i]
//  player_lane  in   2   current player lane
//  score        out  10  caught-block count, binary, saturating
//  lives        out  2   remaining lives
//  game_over    out  1   high while in OVER state
//  hit_pulse    out  1   one-cycle pulse per catch
//  miss_pulse   out  1   one-cycle pulse per miss
// BEHAVIOUR
//  - Clock and reset: single clock clk. rst is asynchronous and active-high.
//  - Reset values: score=0, lives=LIVES, game_over=0, hit_pulse=0, miss_pulse=0.
//    Also at reset: state=IDLE, idx=0, resolved[5:0]=0, pipeline valid=0.
//  - FSM states: IDLE, SCAN, OVER.
//    IDLE -> SCAN on a scene[0] rising edge (scene[0] registered as prev).
//      On entry: score<=0, lives<=LIVES, resolved<=0, idx<=0.
//    SCAN -> IDLE when scene[0]=0. Score and lives hold.
//    SCAN -> OVER on the same edge at which lives is decremented to 0.
//    OVER -> IDLE when scene[0]=0. game_over=1 only while the state is OVER.
//  - Scanner (SCAN only): idx steps 0,1,..,5,0 one slot per clk; a full sweep takes 6 cycles.
//    idx wraps 5->0.
//  - Stage 1 (edge E): register pos=slot[idx], lane=blocks[idx], idx, and valid=1.
//  - Stage 2 (edge E+1), applied only in SCAN with valid=1. For slot k=idx_s1:
//    * resolved[k]=0, CATCH_LO<=pos<=CATCH_HI, lane==player_lane:
//      catch -> resolved[k]<=1; hit_pulse<=1; score<=min(score+1, SCORE_MAX).
//    * resolved[k]=0, pos==LAND_POS: miss -> resolved[k]<=1; miss_pulse<=1; lives<=lives-1.
//    * pos>LAND_POS (parked 481/482, pre-roll >=900): resolved[k]<=0, re-arming the slot.
//    * Otherwise no change.
//    Pulses are low in every other cycle. At most one event per cycle, because one slot is
//    examined per cycle.
//  - Latency: a slot condition sampled at edge E is visible on the outputs after edge E+1.
//  - A block held at one position for many clk cycles (clk_mov is much slower than clk)
//    yields one event only.
//  - A caught block that later reaches LAND_POS is not a miss.
//  - Lives never underflow: the miss taking lives to 0 enters OVER.
//    In OVER and IDLE, stage 2 is discarded and the pipeline valid is cleared.
//  - Score at SCORE_MAX stays at SCORE_MAX; hit_pulse still fires.
//  - player_lane changing mid-window: the value sampled at stage 2 decides.
//  - rst asserted mid-sweep: all outputs and state return to reset values immediately,
//    with no pulse emitted.
// TESTING
//  T1 rst=1 -> score=0, lives=3, game_over=0, hit/miss_pulse=0; release rst, scene=0 ->
//     outputs hold.
//  T2 scene 0->1; slot2 pos=395 lane=1, player_lane=1 held 500 cycles -> exactly one
//     hit_pulse, score=1. Slot2 then set to 410 -> no miss_pulse, lives=3.
//  T3 slot0 pos=410 lane=3, player_lane=0 held 300 cycles -> exactly one miss_pulse,
//     lives=2. Slot0 ->482 ->911 ->410 -> second miss, lives=1.
//  T4 third miss -> lives=0, game_over=1 the next cycle. Slot4 pos=390 in lane -> no
//     hit_pulse, score unchanged. Then scene 1->0->1 -> score=0, lives=3, game_over=0.
//  T5 800 cycles after 999 re-armed catches (slot cycled 400 -> 482 -> 400) -> score=999.
//     Next catch: score=999, hit_pulse=1.
//  T6 slot1 pos=400 lane match, rst pulsed 1 cycle after stage-1 capture -> no hit_pulse,
//     score=0. After restart the catch is counted once.

Source files
------------

// File: rtl/catch_judge_if.sv
// Falling-block bus between the block generator/scene controller and the catch judge.
// Carries the slot snapshot and player lane in, and score/lives/event pulses out.
interface catch_judge_if;
    logic [1:0]  scene;
    logic [59:0] pos_blocks;
    logic [11:0] blocks;
    logic [1:0]  player_lane;
    logic [9:0]  score;
    logic [1:0]  lives;
    logic        game_over;
    logic        hit_pulse;
    logic        miss_pulse;

    modport master (
        output scene, pos_blocks, blocks, player_lane,
        input  score, lives, game_over, hit_pulse, miss_pulse
    );

    modport slave (
        input  scene, pos_blocks, blocks, player_lane,
        output score, lives, game_over, hit_pulse, miss_pulse
    );
endinterface

// File: rtl/catch_judge.sv
// Sweeps the six falling-block slots one per clock and resolves each fall exactly once
// as a catch or a miss, tracking score, lives and the game-over state.
module catch_judge #(
    parameter int CATCH_LO  = 380,
    parameter int CATCH_HI  = 409,
    parameter int LAND_POS  = 410,
    parameter int LIVES     = 3,
    parameter int SCORE_MAX = 999
) (
    input  logic          clk,
    input  logic          rst,
    catch_judge_if.slave  bus
);
    localparam logic [9:0] WIN_LO     = 10'(CATCH_LO);
    localparam logic [9:0] WIN_HI     = 10'(CATCH_HI);
    localparam logic [9:0] LAND       = 10'(LAND_POS);
    localparam logic [9:0] SAT        = 10'(SCORE_MAX);
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);

    typedef enum logic [1:0] {IDLE, SCAN, OVER} state_t;

    state_t          state;
    logic            scene_prev;
    logic [2:0]      idx;
    logic [2:0]      idx_s1;
    logic [9:0]      pos_s1;
    logic [1:0]      lane_s1;
    logic            vld_s1;
    logic [5:0]      resolved;
    logic [5:0][9:0] slot_pos;
    logic [5:0][1:0] slot_lane;

    logic playing, start;
    logic unresolved, in_window, is_catch, is_miss, is_park;
    logic unused_scene;

    assign slot_pos     = bus.pos_blocks;
    assign slot_lane    = bus.blocks;
    assign playing      = bus.scene[0];
    assign start        = playing & ~scene_prev;
    assign unused_scene = bus.scene[1];

    // Stage-2 classification of the slot captured on the previous clock.
    assign unresolved = ~resolved[idx_s1];
    assign in_window  = (pos_s1 >= WIN_LO) && (pos_s1 <= WIN_HI);
    assign is_catch   = vld_s1 && unresolved && in_window && (lane_s1 == bus.player_lane);
    assign is_miss    = vld_s1 && unresolved && (pos_s1 == LAND);
    assign is_park    = vld_s1 && (pos_s1 > LAND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            scene_prev     <= 1'b0;
            idx            <= 3'd0;
            idx_s1         <= 3'd0;
            pos_s1         <= 10'd0;
            lane_s1        <= 2'd0;
            vld_s1         <= 1'b0;
            resolved       <= 6'd0;
            bus.score      <= 10'd0;
            bus.lives      <= LIVES_INIT;
            bus.game_over  <= 1'b0;
            bus.hit_pulse  <= 1'b0;
            bus.miss_pulse <= 1'b0;
        end else begin
            scene_prev     <= playing;
            bus.hit_pulse  <= 1'b0;
            bus.miss_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    vld_s1 <= 1'b0;
                    if (start) begin
                        state     <= SCAN;
                        bus.score <= 10'd0;
                        bus.lives <= LIVES_INIT;
                        resolved  <= 6'd0;
                        idx       <= 3'd0;
                    end
                end
                SCAN: begin
                    if (!playing) begin
                        state  <= IDLE;
                        vld_s1 <= 1'b0;
                    end else begin
                        pos_s1  <= slot_pos[idx];
                        lane_s1 <= slot_lane[idx];
                        idx_s1  <= idx;
                        vld_s1  <= 1'b1;
                        idx     <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
                        if (is_catch) begin
                            resolved[idx_s1] <= 1'b1;
                            bus.hit_pulse    <= 1'b1;
                            if (bus.score != SAT) bus.score <= bus.score + 10'd1;
                        end else if (is_miss) begin
                            resolved[idx_s1] <= 1'b1;
                            bus.miss_pulse   <= 1'b1;
                            bus.lives        <= bus.lives - 2'd1;
                            // Last life gone: freeze in OVER and drop the in-flight capture.
                            if (bus.lives == 2'd1) begin
                                state         <= OVER;
                                bus.game_over <= 1'b1;
                                vld_s1        <= 1'b0;
                            end
                        end else if (is_park) begin
                            resolved[idx_s1] <= 1'b0;
                        end
                    end
                end
                OVER: begin
                    vld_s1 <= 1'b0;
                    if (!playing) begin
                        state         <= IDLE;
                        bus.game_over <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
